// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared state encoding and constants for the sequential divider
package seq_divider_pkg;

  // Default operand/result width.
  localparam int DIV_WIDTH = 32;

  // Widest operand the all-ones constant below covers.
  localparam int DIV_MAX_WIDTH = 64;

  // FSM state encoding.
  typedef logic [1:0] div_state_t;
  localparam div_state_t ST_IDLE = 2'd0;
  localparam div_state_t ST_CALC = 2'd1;
  localparam div_state_t ST_DONE = 2'd2;

  // Quotient reported for a division by zero; sliced down to the operand width.
  localparam logic [DIV_MAX_WIDTH-1:0] DIV_ZERO_QUOTIENT = {DIV_MAX_WIDTH{1'b1}};

endpackage

// File: rtl/seq_divider_div_trial_sub.sv
// rtl/seq_divider_div_trial_sub.sv - WIDTH-bit trial subtractor (a + ~b + 1) with carry-out
module div_trial_sub
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             co
);

  logic [WIDTH:0] sum;

  // co=1 means no borrow, i.e. a >= b.
  assign sum  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign diff = sum[WIDTH-1:0];
  assign co   = sum[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle unsigned restoring divider with start/done handshake
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] b_q;

  logic             msb;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] diff;
  logic             co;
  logic             ge;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

  // Shift the next dividend bit into the partial remainder; the bit leaving R
  // means the shifted value is at least 2^WIDTH > b, so the trial must succeed.
  assign msb = r_q[WIDTH-1];
  assign rs  = {r_q[WIDTH-2:0], q_q[WIDTH-1]};

  div_trial_sub #(.WIDTH(WIDTH)) u_trial (
    .a    (rs),
    .b    (b_q),
    .diff (diff),
    .co   (co)
  );

  assign ge     = msb | co;
  assign r_next = ge ? diff : rs;
  assign q_next = {q_q[WIDTH-2:0], ge};

  // FSM, iteration counter, shift registers and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      r_q       <= '0;
      q_q       <= '0;
      b_q       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (b != '0) begin
              b_q      <= b;
              q_q      <= a;
              r_q      <= '0;
              cnt      <= '0;
              div_zero <= 1'b0;
              busy     <= 1'b1;
              state    <= ST_CALC;
            end else begin
              quotient  <= DIV_ZERO_QUOTIENT[WIDTH-1:0];
              remainder <= a;
              div_zero  <= 1'b1;
              done      <= 1'b1;
              state     <= ST_DONE;
            end
          end
        end
        ST_CALC: begin
          r_q <= r_next;
          q_q <= q_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            quotient  <= q_next;
            remainder <= r_next;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - randomized self-checking bench for seq_divider
module tb_seq_divider;

  localparam int W = 32;

  logic         clk;
  logic         rstn;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] prev_q = '0;
  logic [W-1:0] prev_r = '0;
  logic         prev_done = 1'b0;

  seq_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Protocol monitor: done is a single-cycle pulse and never overlaps busy.
  always @(negedge clk) begin
    if (rstn && done) begin
      check("done_single_pulse", {63'd0, prev_done}, 64'd0);
      check("busy_low_in_done", {63'd0, busy}, 64'd0);
    end
    prev_done <= rstn ? done : 1'b0;
  end

  // One division from IDLE; optionally re-pulse start with other operands mid-CALC.
  task automatic run_div(input logic [W-1:0] ai, input logic [W-1:0] bi, input bit repulse);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    int           cycles;
    int           exp_lat;
    eq      = (bi == 0) ? {W{1'b1}} : ai / bi;
    er      = (bi == 0) ? ai : ai % bi;
    exp_lat = (bi == 0) ? 1 : W + 1;
    @(negedge clk);
    a = ai; b = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 1;
    if (bi != 0) begin
      check("busy_in_calc", {63'd0, busy}, 64'd1);
      check("quot_held_in_calc", {32'd0, quotient}, {32'd0, prev_q});
      check("rem_held_in_calc", {32'd0, remainder}, {32'd0, prev_r});
      check("div_zero_cleared", {63'd0, div_zero}, 64'd0);
    end
    while (!done && cycles < 100) begin
      if (repulse && cycles == 5) begin
        a = ~ai; b = (bi >> 1) | 32'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    check("latency", 64'(cycles), 64'(exp_lat));
    check("quotient", {32'd0, quotient}, {32'd0, eq});
    check("remainder", {32'd0, remainder}, {32'd0, er});
    check("div_zero", {63'd0, div_zero}, {63'd0, bi == 0});
    prev_q = eq;
    prev_r = er;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_done"}, {63'd0, done}, 64'd0);
    check({tag, "_quot"}, {32'd0, quotient}, 64'd0);
    check({tag, "_rem"}, {32'd0, remainder}, 64'd0);
    check({tag, "_dz"}, {63'd0, div_zero}, 64'd0);
  endtask

  initial begin
    int           gap;
    int           seen;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    rstn = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rstn = 1'b1;

    // Directed cases.
    run_div(32'd100, 32'd7, 1'b0);
    run_div(32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_div(32'd5, 32'd9, 1'b0);
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0);
    run_div(32'h1234, 32'd0, 1'b0);
    run_div(32'd77, 32'd3, 1'b0);
    run_div(32'd0, 32'd13, 1'b0);
    run_div(32'hDEAD_BEEF, 32'h0001_0001, 1'b1);

    // Reset in the middle of a calculation.
    @(negedge clk);
    a = 32'h5555_AAAA; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rstn = 1'b0;
    #1;
    check_reset_outputs("midcalc_reset");
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("no_done_after_abort", 64'(seen), 64'd0);
    rstn = 1'b1;
    prev_q = '0;
    prev_r = '0;
    run_div(32'd1000, 32'd33, 1'b0);

    // Back-to-back with start held high.
    @(negedge clk);
    a = 32'd999; b = 32'd10; start = 1'b1;
    seen = 0;
    while (!done && seen < 100) begin @(negedge clk); seen++; end
    check("b2b_first_done", {63'd0, done}, 64'd1);
    gap = 0;
    do begin @(negedge clk); gap++; end while (!done && gap < 100);
    check("b2b_period", 64'(gap), 64'(W + 2));
    check("b2b_quot", {32'd0, quotient}, 64'd99);
    start = 1'b0;
    @(negedge clk);
    prev_q = 32'd99;
    prev_r = 32'd9;

    // Randomized divisions against plain-arithmetic reference.
    for (int i = 0; i < 1500; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = (i % 16 == 0) ? 32'd0 : 32'($urandom_range(1, 15));
        1: rb = $urandom >> $urandom_range(0, 31);
        2: rb = ra >> $urandom_range(0, 8);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) ra = ra >> $urandom_range(0, 31);
      run_div(ra, rb, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
